fcvt_int_pipe: RTL

Pipelined, parametrised double-precision to integer converter for the FPU FCVT path, replacing the single-cycle truncate-only converter. Accepts one IEEE-754 binary64 operand per cycle over a valid/ready handshake, converts to a signed or unsigned integer of width IW under a per-operation rounding mode, saturates out-of-range inputs and reports RISC-V fflags. Sits between FPU issue and the integer writeback mux.

---
 rtl/fcvt_int_pipe_if.sv | 23 ++
 rtl/fcvt_int_pipe.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/fcvt_int_pipe_if.sv
// Handshake and data bundle for the FCVT float-to-integer pipeline.
// The master side presents operands and accepts results; the slave side is the converter.
interface fcvt_int_pipe_if;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] fp;
    logic [2:0]  rm;
    logic        is_unsigned;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] result;
    logic [4:0]  fflags;

    modport master (
        output in_valid, fp, rm, is_unsigned, out_ready,
        input  in_ready, out_valid, result, fflags
    );

    modport slave (
        input  in_valid, fp, rm, is_unsigned, out_ready,
        output in_ready, out_valid, result, fflags
    );
endinterface

// File: rtl/fcvt_int_pipe.sv
// fcvt_int_pipe: three-stage binary64 -> IW-bit integer converter (IW = 32 or 64) with NV/NX flags.
// Build option FCVT_INT_RM_EN enables RNE/RTZ/RDN/RUP/RMM; without it every conversion truncates.
module fcvt_int_pipe #(
    parameter int unsigned IW = 64
) (
    input logic            clk,
    input logic            rst,
    fcvt_int_pipe_if.slave bus
);

`ifdef FCVT_INT_RM_EN
    typedef enum logic [2:0] {
        RM_RNE = 3'd0,
        RM_RTZ = 3'd1,
        RM_RDN = 3'd2,
        RM_RUP = 3'd3,
        RM_RMM = 3'd4
    } rm_e;
`endif

    localparam logic signed [12:0] E_BIG = 13'(IW + 1);
    localparam logic [65:0]        SMAX  = (66'd1 << (IW - 1)) - 66'd1;
    localparam logic [65:0]        UMAX  = (66'd1 << IW) - 66'd1;
    localparam logic [63:0]        POS_S = SMAX[63:0];
    localparam logic [63:0]        NEG_S = ~SMAX[63:0];

    // Narrow results are always sign-extended from bit IW-1, signed or not.
    function automatic logic [63:0] fit(input logic [63:0] x);
        if (IW == 32) return {{32{x[31]}}, x[31:0]};
        return x;
    endfunction

    // ---------------- pipeline control ----------------
    logic v1, v2, v3;
    logic adv1, adv2, adv3;
    logic ld1, ld2, ld3;

    always_comb begin
        adv3 = v3 & bus.out_ready;
        ld3  = !v3 | adv3;
        adv2 = v2 & ld3;
        ld2  = !v2 | adv2;
        adv1 = v1 & ld2;
        ld1  = !v1 | adv1;
    end

    assign bus.in_ready  = ld1;
    assign bus.out_valid = v3;

    // ---------------- stage 1: unpack ----------------
    logic        s1_sign;
    logic [10:0] s1_exp;
    logic [52:0] s1_man;
    logic        s1_nan;
    logic        s1_uns;
`ifdef FCVT_INT_RM_EN
    rm_e         s1_rm;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1      <= 1'b0;
            s1_sign <= 1'b0;
            s1_exp  <= '0;
            s1_man  <= '0;
            s1_nan  <= 1'b0;
            s1_uns  <= 1'b0;
`ifdef FCVT_INT_RM_EN
            s1_rm   <= RM_RNE;
`endif
        end else begin
            if (ld1) v1 <= bus.in_valid;
            if (ld1 && bus.in_valid) begin
                s1_sign <= bus.fp[63];
                s1_exp  <= bus.fp[62:52];
                s1_man  <= {|bus.fp[62:52], bus.fp[51:0]};
                s1_nan  <= (&bus.fp[62:52]) & (|bus.fp[51:0]);
                s1_uns  <= bus.is_unsigned;
`ifdef FCVT_INT_RM_EN
                s1_rm   <= (bus.rm > 3'd4) ? RM_RTZ : rm_e'(bus.rm);
`endif
            end
        end
    end

    // ---------------- stage 2: align ----------------
    // Fixed point with 53 fraction bits: the significand lands at bit (e+1),
    // so the top 65 bits are the integer part, then guard, then sticky bits.
    logic signed [12:0] e_unb;
    logic [6:0]         shamt;
    logic [117:0]       wide;
    logic [64:0]        a_int;
    logic               a_guard, a_sticky, a_big;

    always_comb begin
        e_unb    = $signed({2'b00, s1_exp}) - 13'sd1023;
        shamt    = 7'(e_unb + 13'sd1);
        wide     = '0;
        a_int    = '0;
        a_guard  = 1'b0;
        a_sticky = 1'b0;
        a_big    = 1'b0;
        if (s1_exp == 11'd0) begin
            a_sticky = |s1_man[51:0];
        end else if (e_unb >= E_BIG) begin
            a_big = 1'b1;              // also covers Inf/NaN (e = 1024)
        end else if (e_unb < -13'sd1) begin
            a_sticky = 1'b1;
        end else begin
            wide     = {65'd0, s1_man} << shamt;
            a_int    = wide[117:53];
            a_guard  = wide[52];
            a_sticky = |wide[51:0];
        end
    end

    logic        s2_sign, s2_nan, s2_big, s2_uns;
    logic [64:0] s2_int;
    logic        s2_guard, s2_sticky;
`ifdef FCVT_INT_RM_EN
    rm_e         s2_rm;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v2        <= 1'b0;
            s2_sign   <= 1'b0;
            s2_nan    <= 1'b0;
            s2_big    <= 1'b0;
            s2_uns    <= 1'b0;
            s2_int    <= '0;
            s2_guard  <= 1'b0;
            s2_sticky <= 1'b0;
`ifdef FCVT_INT_RM_EN
            s2_rm     <= RM_RNE;
`endif
        end else begin
            if (ld2) v2 <= v1;
            if (ld2 && v1) begin
                s2_sign   <= s1_sign;
                s2_nan    <= s1_nan;
                s2_big    <= a_big;
                s2_uns    <= s1_uns;
                s2_int    <= a_int;
                s2_guard  <= a_guard;
                s2_sticky <= a_sticky;
`ifdef FCVT_INT_RM_EN
                s2_rm     <= s1_rm;
`endif
            end
        end
    end

    // ---------------- stage 3: round, negate, saturate ----------------
    logic        inexact;
    logic [65:0] mag;
    logic [65:0] lim_pos, lim_neg;
    logic        ovf;
    logic [63:0] res_n;
    logic [4:0]  flags_n;
`ifdef FCVT_INT_RM_EN
    logic        inc;
`endif

    always_comb begin
        inexact = s2_guard | s2_sticky;
`ifdef FCVT_INT_RM_EN
        case (s2_rm)
            RM_RNE:  inc = s2_guard & (s2_sticky | s2_int[0]);
            RM_RDN:  inc = s2_sign & inexact;
            RM_RUP:  inc = !s2_sign & inexact;
            RM_RMM:  inc = s2_guard;
            default: inc = 1'b0;
        endcase
        mag = {1'b0, s2_int} + {65'd0, inc};
`else
        mag = {1'b0, s2_int};
`endif
        lim_pos = s2_uns ? UMAX : SMAX;
        lim_neg = s2_uns ? 66'd0 : SMAX + 66'd1;
        ovf     = s2_big | (s2_sign ? (mag > lim_neg) : (mag > lim_pos));
        res_n   = '0;
        flags_n = '0;
        if (s2_nan || (ovf && !s2_sign)) begin
            res_n   = s2_uns ? '1 : POS_S;
            flags_n = 5'b10000;
        end else if (ovf) begin
            res_n   = s2_uns ? '0 : NEG_S;
            flags_n = 5'b10000;
        end else begin
            res_n   = fit(s2_sign ? -mag[63:0] : mag[63:0]);
            flags_n = {4'b0000, inexact};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v3         <= 1'b0;
            bus.result <= '0;
            bus.fflags <= '0;
        end else begin
            if (ld3) v3 <= v2;
            if (ld3 && v2) begin
                bus.result <= res_n;
                bus.fflags <= flags_n;
            end
        end
    end

endmodule
